// File: rtl/timer_pkg.sv
// Shared definitions for the tick countdown timer: FSM encodings, BCD limits,
// segment constants and the mm:ss BCD time payload.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
    localparam logic [6:0] SEG_BLANK        = 7'h7F;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_units;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
    } bcd_time_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_to_hex7.sv
// BCD digit to active-low seven-segment pattern (a..g = bit0..6); non-BCD codes
// and the blank request show all segments off.
module bcd_to_hex7
    import timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/tick_countdown_timer.sv
// mm:ss BCD countdown driven by divider tick pulses, with start/pause/clear/load.
// Optional seven-segment outputs hex0..hex3 when COUNTDOWN_HEX_EN is defined.
module tick_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned WARN_SECS     = 10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_mins,
    input  logic [7:0] load_secs,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] mins_bcd,
    output logic [7:0] secs_bcd,
    output logic       running,
    output logic       warn,
    output logic       expired,
    output logic       done_pulse
`ifdef COUNTDOWN_HEX_EN
    ,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
`endif
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state, state_nx;
    bcd_time_t     tm, tm_nx, tm_dec, tm_load;
    logic [PW-1:0] pre, pre_nx;
    logic          done_nx;
    logic          time_zero;
    logic [6:0]    secs_bin;

    // State, time, prescaler and done pulse registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            tm         <= '0;
            pre        <= '0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            tm         <= tm_nx;
            pre        <= pre_nx;
            done_pulse <= done_nx;
        end
    end

    assign time_zero = (tm == '0);

    // One-second BCD decrement with borrow chain; never called at 00:00
    always_comb begin
        tm_dec = tm;
        if (tm.sec_units != 4'd0) begin
            tm_dec.sec_units = tm.sec_units - 4'd1;
        end else begin
            tm_dec.sec_units = BCD_MAX_UNITS;
            if (tm.sec_tens != 4'd0) begin
                tm_dec.sec_tens = tm.sec_tens - 4'd1;
            end else begin
                tm_dec.sec_tens = BCD_MAX_SEC_TENS;
                if (tm.min_units != 4'd0) begin
                    tm_dec.min_units = tm.min_units - 4'd1;
                end else begin
                    tm_dec.min_units = BCD_MAX_UNITS;
                    tm_dec.min_tens  = tm.min_tens - 4'd1;
                end
            end
        end
    end

    always_comb begin
        tm_load.min_tens  = clamp_digit(load_mins[7:4], BCD_MAX_UNITS);
        tm_load.min_units = clamp_digit(load_mins[3:0], BCD_MAX_UNITS);
        tm_load.sec_tens  = clamp_digit(load_secs[7:4], BCD_MAX_SEC_TENS);
        tm_load.sec_units = clamp_digit(load_secs[3:0], BCD_MAX_UNITS);
    end

    // Next-state: clear > load > pause > start > tick
    always_comb begin
        state_nx = state;
        tm_nx    = tm;
        pre_nx   = pre;
        done_nx  = 1'b0;
        if (clear) begin
            state_nx = ST_IDLE;
            tm_nx    = '0;
            pre_nx   = '0;
        end else if (load) begin
            state_nx = ST_IDLE;
            tm_nx    = tm_load;
            pre_nx   = '0;
        end else if (pause) begin
            if (state == ST_RUN) state_nx = ST_PAUSE;
        end else if (start) begin
            if ((state == ST_IDLE || state == ST_PAUSE) && !time_zero) state_nx = ST_RUN;
        end else if (tick && state == ST_RUN && !time_zero) begin
            if (pre == PRE_LAST) begin
                pre_nx = '0;
                tm_nx  = tm_dec;
                if (tm_dec == '0) begin
                    state_nx = ST_EXPIRED;
                    done_nx  = 1'b1;
                end
            end else begin
                pre_nx = pre + PW'(1);
            end
        end
    end

    assign secs_bin = 7'(tm.sec_tens) * 7'd10 + 7'(tm.sec_units);
    assign mins_bcd = {tm.min_tens, tm.min_units};
    assign secs_bcd = {tm.sec_tens, tm.sec_units};
    assign running  = (state == ST_RUN);
    assign expired  = (state == ST_EXPIRED);
    assign warn     = running && (tm.min_tens == 4'd0) && (tm.min_units == 4'd0)
                      && (secs_bin <= 7'(WARN_SECS));

`ifdef COUNTDOWN_HEX_EN
    bcd_to_hex7 u_hex0 (.digit(tm.sec_units), .blank(!resetn), .seg(hex0));
    bcd_to_hex7 u_hex1 (.digit(tm.sec_tens),  .blank(!resetn), .seg(hex1));
    bcd_to_hex7 u_hex2 (.digit(tm.min_units), .blank(!resetn), .seg(hex2));
    bcd_to_hex7 u_hex3 (.digit(tm.min_tens),  .blank(!resetn), .seg(hex3));
`endif

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Bench for tick_countdown_timer: two instances (1 and 4 ticks/s) against a
// seconds-counting reference model; hex outputs checked when COUNTDOWN_HEX_EN is set.
module tb_tick_countdown_timer;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [7:0] load_mins = '0, load_secs = '0;

    logic [7:0] mins_o [2];
    logic [7:0] secs_o [2];
    logic       run_o [2], warn_o [2], exp_o [2], done_o [2];
`ifdef COUNTDOWN_HEX_EN
    logic [6:0] hx [2][4];
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: remaining time as plain seconds
    int m_rem [2], m_st [2], m_pre [2], m_done [2];
    int tps_k [2] = '{1, 4};
    int warn_k [2] = '{10, 5};

    always #5 clock = ~clock;

    tick_countdown_timer #(.TICKS_PER_SEC(1), .WARN_SECS(10)) u_dut1 (
        .clock(clock), .resetn(resetn), .tick(tick), .load(load),
        .load_mins(load_mins), .load_secs(load_secs), .start(start), .pause(pause),
        .clear(clear), .mins_bcd(mins_o[0]), .secs_bcd(secs_o[0]), .running(run_o[0]),
        .warn(warn_o[0]), .expired(exp_o[0]), .done_pulse(done_o[0])
`ifdef COUNTDOWN_HEX_EN
        , .hex0(hx[0][0]), .hex1(hx[0][1]), .hex2(hx[0][2]), .hex3(hx[0][3])
`endif
    );

    tick_countdown_timer #(.TICKS_PER_SEC(4), .WARN_SECS(5)) u_dut4 (
        .clock(clock), .resetn(resetn), .tick(tick), .load(load),
        .load_mins(load_mins), .load_secs(load_secs), .start(start), .pause(pause),
        .clear(clear), .mins_bcd(mins_o[1]), .secs_bcd(secs_o[1]), .running(run_o[1]),
        .warn(warn_o[1]), .expired(exp_o[1]), .done_pulse(done_o[1])
`ifdef COUNTDOWN_HEX_EN
        , .hex0(hx[1][0]), .hex1(hx[1][1]), .hex2(hx[1][2]), .hex3(hx[1][3])
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int clampd(input int d, input int lim);
        return (d > lim) ? lim : d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_st[k] = 0; m_pre[k] = 0; m_done[k] = 0;
        end
    endtask

    // 0 idle, 1 run, 2 pause, 3 expired
    task automatic model_step();
        int mins, secs;
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            if (clear) begin
                m_st[k] = 0; m_rem[k] = 0; m_pre[k] = 0;
            end else if (load) begin
                mins = clampd(int'(load_mins[7:4]), 9) * 10 + clampd(int'(load_mins[3:0]), 9);
                secs = clampd(int'(load_secs[7:4]), 5) * 10 + clampd(int'(load_secs[3:0]), 9);
                m_st[k] = 0; m_rem[k] = mins * 60 + secs; m_pre[k] = 0;
            end else if (pause) begin
                if (m_st[k] == 1) m_st[k] = 2;
            end else if (start) begin
                if ((m_st[k] == 0 || m_st[k] == 2) && m_rem[k] != 0) m_st[k] = 1;
            end else if (tick && m_st[k] == 1) begin
                m_pre[k]++;
                if (m_pre[k] == tps_k[k]) begin
                    m_pre[k] = 0;
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_st[k] = 3; m_done[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("mins%0d", k), int'(mins_o[k]), to_bcd(m_rem[k] / 60));
            check($sformatf("secs%0d", k), int'(secs_o[k]), to_bcd(m_rem[k] % 60));
            check($sformatf("running%0d", k), int'(run_o[k]), int'(m_st[k] == 1));
            check($sformatf("warn%0d", k), int'(warn_o[k]),
                  int'(m_st[k] == 1 && m_rem[k] <= warn_k[k]));
            check($sformatf("expired%0d", k), int'(exp_o[k]), int'(m_st[k] == 3));
            check($sformatf("done%0d", k), int'(done_o[k]), m_done[k]);
        end
    endtask

    // Drive at negedge, model on posedge, compare at following negedge
    task automatic cyc(input logic c_ld, input logic [7:0] c_lm, input logic [7:0] c_ls,
                       input logic c_st, input logic c_ps, input logic c_clr, input logic c_tk);
        load = c_ld; load_mins = c_lm; load_secs = c_ls;
        start = c_st; pause = c_ps; clear = c_clr; tick = c_tk;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
        cyc(1, lm, ls, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // 01:00 -> 00:59 after one tick
        do_load(8'h01, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("dir_0059_secs", int'(secs_o[0]), 'h59);
        check("dir_0059_run", int'(run_o[0]), 1);

        // 00:01 -> expire, single done pulse, no underflow
        do_load(8'h00, 8'h01);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("dir_exp", int'(exp_o[0]), 1);
        check("dir_done_hi", int'(done_o[0]), 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("dir_done_lo", int'(done_o[0]), 0);
        check("dir_no_underflow", int'(secs_o[0]), 0);
        cyc(0, 0, 0, 1, 0, 0, 1);

        // Prescaler of 4 retained across pause
        do_load(8'h00, 8'h10);
        cyc(0, 0, 0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
        check("dir_pre3", int'(secs_o[1]), 'h10);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("dir_pre_wrap", int'(secs_o[1]), 'h09);

        // 10:00 borrow chain, tick dropped under pause
        do_load(8'h10, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("dir_0959_m", int'(mins_o[0]), 'h09);
        check("dir_0959_s", int'(secs_o[0]), 'h59);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("dir_tick_pause", int'(secs_o[0]), 'h59);
        check("dir_paused", int'(run_o[0]), 0);

        // Clamping, and start at 00:00 ignored
        do_load(8'h9C, 8'hA7);
        check("dir_clamp_m", int'(mins_o[0]), 'h99);
        check("dir_clamp_s", int'(secs_o[0]), 'h57);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("dir_start_zero", int'(run_o[0]), 0);

`ifdef COUNTDOWN_HEX_EN
        do_load(8'h12, 8'h34);
        check("hex3", int'(hx[0][3]), 'h79);
        check("hex2", int'(hx[0][2]), 'h24);
        check("hex1", int'(hx[0][1]), 'h30);
        check("hex0", int'(hx[0][0]), 'h19);
`endif

        // Asynchronous reset between edges while running
        do_load(8'h00, 8'h30);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_rst_secs", int'(secs_o[0]), 0);
`ifdef COUNTDOWN_HEX_EN
        check("hex_blank", int'(hx[0][0]), 'h7F);
`endif
        @(negedge clock);
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Random control mix, biased toward short loads so expiry is reached often
        for (int i = 0; i < 3000; i++) begin
            logic r_clr, r_ld, r_ps, r_st, r_tk;
            logic [7:0] r_lm, r_ls;
            r_clr = ($urandom_range(0, 199) < 1);
            r_ld  = ($urandom_range(0, 99) < 3);
            r_ps  = ($urandom_range(0, 99) < 4);
            r_st  = ($urandom_range(0, 99) < 12);
            r_tk  = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 3) == 0) begin
                r_lm = 8'($urandom);
                r_ls = 8'($urandom);
            end else begin
                r_lm = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
                r_ls = 8'($urandom_range(0, 2) << 4) | 8'($urandom_range(0, 10));
            end
            cyc(r_ld, r_lm, r_ls, r_st, r_ps, r_clr, r_tk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
